// File: rtl/id_pkg.sv
// id_pkg: shared constants and the hazard-cause encoding for the ID/EX issue stage.
package id_pkg;
    localparam int ID_REG_N = 32;
    localparam int ID_RA_W = $clog2(ID_REG_N);
    localparam int ID_PEND_W = 2;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_LOAD_USE,
        HZ_RAW,
        HZ_WAW_SAT
    } hz_e;
endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register outstanding-write counters with saturation and busy queries.
module id_scoreboard
    import id_pkg::*;
#(
    parameter int REG_N = ID_REG_N,
    parameter int RA_W = $clog2(REG_N),
    parameter int PEND_W = ID_PEND_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_en,
    input  logic [RA_W-1:0] inc_rd,
    input  logic            dec_en,
    input  logic [RA_W-1:0] dec_rd,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] wd,
    output logic            rs_busy,
    output logic            rt_busy,
    output logic            wd_sat,
    output logic            sb_err
);
    localparam logic [PEND_W-1:0] MAX = '1;

    logic [PEND_W-1:0] pend [REG_N];
    logic inc, dec, same;

    assign inc = inc_en && int'(inc_rd) != ZERO_REG;
    assign dec = dec_en && int'(dec_rd) != ZERO_REG;
    assign same = inc && dec && inc_rd == dec_rd;

    // register 0 is never written, so its counter stays at the reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_N; r++) pend[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < REG_N; r++) begin
                if (inc && inc_rd == RA_W'(r) && !same)
                    pend[r] <= pend[r] == MAX ? MAX : pend[r] + 1'b1;
                else if (dec && dec_rd == RA_W'(r) && !same && pend[r] != '0)
                    pend[r] <= pend[r] - 1'b1;
            end
            if (dec && !same && pend[dec_rd] == '0) sb_err <= 1'b1;
        end
    end

    assign rs_busy = pend[rs] != '0;
    assign rt_busy = pend[rt] != '0;
    assign wd_sat = pend[wd] == MAX;
endmodule

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: ID/EX issue slot with valid/ready handshake, scoreboard and hazard stalls.
// Define ID_BYPASS_EN when EX/MEM forwarding exists; only load-use and WAW overflow then stall.
module id_issue_ctrl
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N = ID_REG_N,
    parameter int RA_W = $clog2(REG_N),
    parameter int PEND_W = ID_PEND_W,
    parameter int PAY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_rs_re,
    input  logic             id_rt_re,
    input  logic [RA_W-1:0]  id_wd,
    input  logic             id_wreg,
    input  logic             id_load,
    input  logic [PAY_W-1:0] id_payload,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [PAY_W-1:0] ex_payload,
    output logic [RA_W-1:0]  ex_wd,
    output logic             ex_wreg,
    output logic             ex_load,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [RA_W-1:0]  wb_wd,
    output logic             stall_o,
    output logic             sb_err
);
    if (PAY_W < DATA_W) begin : g_pay_chk
        $error("payload narrower than datapath");
    end

    logic accept, consume, ll_valid, slot_hit, ll_hit, load_use, raw, hazard;
    logic rs_busy, rt_busy, wd_sat;
    logic [RA_W-1:0] ll_wd;
    hz_e cause;

    assign accept = id_valid && id_ready;
    assign consume = ex_valid && ex_ready;

    assign slot_hit = ex_valid && ex_wreg && int'(ex_wd) != ZERO_REG &&
                      ((id_rs_re && id_rs == ex_wd) || (id_rt_re && id_rt == ex_wd));
    assign ll_hit = ll_valid && int'(ll_wd) != ZERO_REG &&
                    ((id_rs_re && id_rs == ll_wd) || (id_rt_re && id_rt == ll_wd));
    assign load_use = (slot_hit && ex_load) || ll_hit;
`ifdef ID_BYPASS_EN
    assign raw = 1'b0;
`else
    assign raw = slot_hit || (id_rs_re && rs_busy) || (id_rt_re && rt_busy);
`endif

    always_comb begin
        cause = load_use ? HZ_LOAD_USE : raw ? HZ_RAW : (id_wreg && wd_sat) ? HZ_WAW_SAT : HZ_NONE;
        hazard = cause != HZ_NONE;
        id_ready = !hazard && !flush && (!ex_valid || ex_ready);
        stall_o = id_valid && hazard;
    end

    // flush blocks accept, so a flushed slot always drains even if consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_payload <= '0;
            ex_wd <= '0;
            ex_wreg <= 1'b0;
            ex_load <= 1'b0;
            ll_valid <= 1'b0;
            ll_wd <= '0;
        end else begin
            ll_valid <= consume && ex_load;
            ll_wd <= ex_wd;
            if (accept) begin
                ex_valid <= 1'b1;
                ex_payload <= id_payload;
                ex_wd <= id_wd;
                ex_wreg <= id_wreg;
                ex_load <= id_load;
            end else if (consume || flush) begin
                ex_valid <= 1'b0;
            end
        end
    end

    id_scoreboard #(.REG_N(REG_N), .RA_W(RA_W), .PEND_W(PEND_W)) u_sb (
        .clk(clk),
        .rst(rst),
        .inc_en(consume && ex_wreg),
        .inc_rd(ex_wd),
        .dec_en(wb_valid),
        .dec_rd(wb_wd),
        .rs(id_rs),
        .rt(id_rt),
        .wd(id_wd),
        .rs_busy(rs_busy),
        .rt_busy(rt_busy),
        .wd_sat(wd_sat),
        .sb_err(sb_err)
    );
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: table vectors, corner sequences and random traffic against a reference model.
module tb_id_issue_ctrl;
    localparam int PAY_W = 128;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_ready, id_rs_re, id_rt_re, id_wreg, id_load;
    logic [4:0] id_rs, id_rt, id_wd, ex_wd, wb_wd;
    logic [PAY_W-1:0] id_payload, ex_payload;
    logic ex_valid, ex_ready, ex_wreg, ex_load, flush, wb_valid, stall_o, sb_err;

    always #5 clk = ~clk;

    id_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_re(id_rs_re), .id_rt_re(id_rt_re),
        .id_wd(id_wd), .id_wreg(id_wreg), .id_load(id_load), .id_payload(id_payload),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_payload(ex_payload),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_load(ex_load),
        .flush(flush), .wb_valid(wb_valid), .wb_wd(wb_wd),
        .stall_o(stall_o), .sb_err(sb_err)
    );

    int nvec = 0, nfail = 0;

    int pend [32];
    bit m_v, m_wreg, m_ld, m_llv, m_err;
    int m_wd, m_llwd;
    logic [PAY_W-1:0] m_pay;

    typedef struct {
        bit v; int rs; int rt; bit re; int wd; bit wreg; bit er; bit wbv; int wbd;
        bit x_rdy; bit x_stall; bit x_exv;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [PAY_W-1:0] act, input logic [PAY_W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit uses(int r);
        return r != 0 && ((id_rs_re && int'(id_rs) == r) || (id_rt_re && int'(id_rt) == r));
    endfunction

    function automatic bit m_hz();
        bit h;
        h = (m_v && m_wreg && m_ld && uses(m_wd)) || (m_llv && uses(m_llwd)) ||
            (id_wreg && pend[id_wd] == MAXP);
`ifndef ID_BYPASS_EN
        h = h || (id_rs_re && pend[id_rs] != 0) || (id_rt_re && pend[id_rt] != 0) ||
            (m_v && m_wreg && uses(m_wd));
`endif
        return h;
    endfunction

    function automatic bit m_rdy();
        return !m_hz() && !flush && (!m_v || ex_ready);
    endfunction

    task automatic m_reset();
        foreach (pend[r]) pend[r] = 0;
        m_v = 0; m_pay = '0; m_wd = 0; m_wreg = 0; m_ld = 0; m_llv = 0; m_llwd = 0; m_err = 0;
    endtask

    task automatic step();
        bit acc, cons;
        int inc, dec;
        #1;
        chk("id_ready", id_ready, m_rdy());
        chk("stall_o", stall_o, id_valid && m_hz());
        chk("ex_valid", ex_valid, m_v);
        chk("sb_err", sb_err, m_err);
        if (m_v) begin
            chk("ex_wd", ex_wd, m_wd);
            chk("ex_wreg", ex_wreg, m_wreg);
            chk("ex_load", ex_load, m_ld);
            chk("ex_payload", ex_payload, m_pay);
        end
        acc = id_valid && m_rdy();
        cons = m_v && ex_ready;
        @(posedge clk);
        if (rst) m_reset();
        else begin
            inc = (cons && m_wreg && m_wd != 0) ? m_wd : -1;
            dec = (wb_valid && wb_wd != 0) ? int'(wb_wd) : -1;
            if (inc != dec) begin
                if (inc > 0 && pend[inc] < MAXP) pend[inc]++;
                if (dec > 0) begin
                    if (pend[dec] == 0) m_err = 1;
                    else pend[dec]--;
                end
            end
            m_llv = cons && m_ld;
            m_llwd = m_wd;
            if (acc) begin
                m_v = 1; m_pay = id_payload; m_wd = id_wd; m_wreg = id_wreg; m_ld = id_load;
            end else if (cons || flush) m_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit re, input int wd,
                         input bit wreg, input bit ld, input bit er, input bit fl,
                         input bit wbv, input int wbd);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_re = re; id_rt_re = re;
        id_wd = 5'(wd); id_wreg = wreg; id_load = ld; ex_ready = er; flush = fl;
        wb_valid = wbv; wb_wd = 5'(wbd);
        id_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle(input bit er, input bit wbv, input int wbd);
        drive(0, 0, 0, 0, 0, 0, 0, er, 0, wbv, wbd);
    endtask

    task automatic do_reset();
        idle(1, 0, 0);
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        int stalls, exp_stalls;
        bit s, r;
        rst = 1;
        idle(0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ex_valid", ex_valid, 0);
        chk("rst ex_payload", ex_payload, 0);
        chk("rst ex_wd", ex_wd, 0);
        chk("rst ex_wreg", ex_wreg, 0);
        chk("rst ex_load", ex_load, 0);
        chk("rst sb_err", sb_err, 0);
        rst = 0;

        for (int i = 0; i < 17; i++) begin
            if (i < 8) tbl[i] = '{1, 10 + i, 20 + i, 1, 1 + i, 1, 1, 0, 0, 1, 0, i > 0};
            else if (i == 8) tbl[i] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
            else tbl[i] = '{0, 0, 0, 0, 0, 0, 1, 1, i - 8, 1, 0, 0};
        end
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].re, tbl[i].wd, tbl[i].wreg, 0,
                  tbl[i].er, 0, tbl[i].wbv, tbl[i].wbd);
            #1;
            chk("stream id_ready", id_ready, tbl[i].x_rdy);
            chk("stream stall_o", stall_o, tbl[i].x_stall);
            chk("stream ex_valid", ex_valid, tbl[i].x_exv);
            step();
        end

        do_reset();
        drive(1, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0);
        step();
        idle(1, 0, 0);
        step();
        stalls = 0;
`ifdef ID_BYPASS_EN
        exp_stalls = 1;
`else
        exp_stalls = 3;
`endif
        for (int k = 0; k < 10; k++) begin
            drive(1, 5, 5, 1, 6, 1, 0, 1, 0, exp_stalls == 3 && k == 2, 5);
            #1;
            s = stall_o;
            r = id_ready;
            step();
            if (s) stalls++;
            if (r) break;
        end
        chk("load_use stalls", stalls, exp_stalls);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
            step();
            idle(1, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        #1 chk("waw stall", stall_o, 1);
        step();
        drive(1, 0, 0, 0, 7, 1, 0, 1, 0, 1, 7);
        #1 chk("waw stall at wb", stall_o, 1);
        step();
        drive(1, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        #1 chk("waw issue", id_ready, 1);
        step();

        do_reset();
        drive(1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 11, 1, 0, 0, 1, 0, 0);
        #1 chk("flush id_ready", id_ready, 0);
        step();
        idle(0, 0, 0);
        #1 chk("flush ex_valid", ex_valid, 0);
        step();
        idle(0, 1, 2);
        step();
        idle(0, 0, 0);
        #1 chk("flush pend untouched", sb_err, 1);
        step();

        do_reset();
        drive(1, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
        step();
        idle(1, 0, 0);
        step();
        drive(1, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
        step();
        idle(1, 1, 3);
        step();
        idle(1, 1, 3);
        step();
        idle(1, 0, 0);
        #1 chk("simul pend kept", sb_err, 0);
        step();
        idle(1, 1, 3);
        step();
        idle(1, 0, 0);
        #1 chk("simul pend drained", sb_err, 1);
        step();
        do_reset();
        idle(1, 1, 9);
        step();
        for (int k = 0; k < 3; k++) begin
            idle(1, 0, 0);
            #1 chk("sb_err sticky", sb_err, 1);
            step();
        end
        do_reset();
        #1 chk("sb_err cleared", sb_err, 0);

        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
            step();
            idle(1, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        step();
        drive(1, 4, 0, 1, 12, 1, 0, 0, 0, 0, 0);
        #1 chk("rst consumer stalled", stall_o, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("post rst ex_valid", ex_valid, 0);
        chk("post rst ex_payload", ex_payload, 0);
        chk("post rst ex_wd", ex_wd, 0);
        chk("post rst id_ready", id_ready, 1);
        step();
        idle(0, 0, 0);
        #1;
        chk("post rst issue valid", ex_valid, 1);
        chk("post rst issue wd", ex_wd, 12);
        step();

        do_reset();
        for (int k = 0; k < 800; k++) begin
            int wr, wbd;
            bit wbv;
            wr = 1 + $urandom % 7;
            wbv = (pend[wr] > 0 && $urandom % 3 == 0) || $urandom % 60 == 0;
            wbd = wbv ? wr : 0;
            drive($urandom % 4 != 0, $urandom % 8, $urandom % 8, $urandom % 2, $urandom % 8,
                  $urandom % 4 != 0, $urandom % 4 == 0, $urandom % 4 != 0, $urandom % 16 == 0,
                  wbv, wbd);
            id_rt_re = 1'($urandom % 2);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Parametrised decode-to-execute issue stage. It holds the decoded instruction in a registered ID/EX slot with a valid/ready handshake and tracks outstanding register writes in a per-register scoreboard. It stalls issue on RAW hazards, load-use hazards and scoreboard overflow, and supports a branch flush of the held slot. It sits between the combinational decoder and the EX stage, replacing the fixed-width, stall-free ID output path.

## Interface
Parameters:
- DATA_W, 32: datapath width (informational; payload carries operands).
- REG_N, 32: architectural register count; register 0 is hard-wired zero.
- RA_W, $clog2(REG_N): register address width.
- PEND_W, 2: per-register pending-write counter width; maximum outstanding writes per register is 2^PEND_W-1.
- PAY_W, 128: opaque decoded payload width (aluop, alusel, operands, pc, inst).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- id_valid  in  1  decoder presents an instruction.
- id_ready  out  1  instruction accepted this cycle when id_valid && id_ready.
- id_rs / id_rt  in  RA_W  source register numbers.
- id_rs_re / id_rt_re  in  1  source read enables.
- id_wd  in  RA_W  destination register.
- id_wreg  in  1  instruction writes id_wd.
- id_load  in  1  instruction is a load.
- id_payload  in  PAY_W  decoded fields, passed through unmodified.
- ex_valid  out  1  ID/EX slot holds an instruction.
- ex_ready  in  1  EX consumes the slot when ex_valid && ex_ready.
- ex_payload / ex_wd / ex_wreg / ex_load  out  PAY_W / RA_W / 1 / 1  registered copies.
- flush  in  1  branch redirect: kill the ID/EX slot.
- wb_valid / wb_wd  in  1 / RA_W  writeback retires one write to wb_wd.
- stall_o  out  1  id_valid is blocked by a hazard (not by backpressure).
- sb_err  out  1  sticky: writeback retired with a zero counter.

## Operation
- Slot: loaded on accept; cleared on an EX consume with no same-cycle accept; holds otherwise.
- Scoreboard: counter pend[r], incremented when an instruction with ex_wreg and ex_wd≠0 is consumed by EX. Decremented on wb_valid for wb_wd≠0. Simultaneous increment and decrement of the same register leaves it unchanged.
- Decrement of a zero counter: counter stays 0, sb_err is set and held until rst.
- Source match: id_rs with id_rs_re, or id_rt with id_rt_re, equal to a given register, where that register ≠0.
- Base hazards:
  - A source matches the slot's ex_wd while the slot is valid with ex_wreg, and the slot is a load.
  - A source matches the destination of the load consumed by EX in the previous cycle (one-entry last_load register).
  - id_wreg && pend[id_wd] is saturated (WAW overflow).
- id_ready = !hazard && !flush && (!ex_valid || ex_ready).
- stall_o = id_valid && hazard.
- Flush: the slot is cleared next cycle and id_ready=0 in the flush cycle. A slot with ex_ready and flush in the same cycle counts as consumed (the scoreboard increments), then the slot clears. The scoreboard and last_load are otherwise untouched.
- Reset: ex_valid=0, ex_payload=0, ex_wd=0, ex_wreg=0, ex_load=0, all pend=0, last_load invalid, sb_err=0.

## Timing
- Latency: accept at edge N, ex_valid=1 at N+1. Back-to-back issue at 1 per cycle when there is no hazard.
- id_ready and stall_o are combinational from the inputs and state. ex_* outputs are registered only.
- last_load is valid for exactly one cycle after the consuming edge.
- rst dominates flush, wb_valid and all handshakes in the same cycle.

## Configuration
- ID_BYPASS_EN defined: EX/MEM forwarding exists downstream, so only the base hazards apply.
- ID_BYPASS_EN undefined: no forwarding. The following also stall:
  - Any source with pend[src]≠0.
  - Any source matching the valid slot's ex_wd when ex_wreg is set, regardless of load.

## Structure
- Package id_pkg: RA_W, the default PEND_W, the zero-register constant, and the hazard-cause enum {HZ_NONE, HZ_LOAD_USE, HZ_RAW, HZ_WAW_SAT}, exported for debug.
- Sub-module id_scoreboard: the pend array, increment/decrement/saturation logic, sb_err, and per-source busy/saturated query outputs.
- id_issue_ctrl: the slot register, last_load, hazard combine and handshake.

## Test plan
- Independent stream: 8 instructions, ex_ready=1, no shared registers -> 8 consecutive ex_valid cycles starting 1 cycle after the first accept, stall_o never set.
- Load-use: load to r5, then add reading r5 -> exactly 1 stall cycle with bypass; with ID_BYPASS_EN undefined, stall until wb_valid wb_wd=5.
- WAW saturation with PEND_W=2: 3 writes to r7 consumed with no writeback -> the 4th writer to r7 stalls; one wb_wd=7 -> it issues next cycle.
- Flush: slot holds an instruction, flush=1, ex_ready=0 -> ex_valid=0 next cycle, pend unchanged, id_ready=0 during flush.
- Simultaneous: consume a writer of r3 and wb_wd=3 in the same cycle with pend[3]=1 -> pend[3] stays 1. A stray wb_wd=9 with pend[9]=0 -> sb_err=1 until rst.
- rst mid-stall: pend[4]=2 with a stalled consumer of r4, assert rst -> all outputs at reset values, consumer accepted the cycle after rst falls.
